// File: rtl/mpc_pkg.sv
// Shared definitions for the MPC incremental-conductance controller.
//   mpc_state_e : controller FSM states
//   PROD_MULT   : products are formed at PROD_MULT*WIDTH bits before they are
//                 shifted and saturated back to WIDTH
//   DEF_*       : default Q16.16 data format and controller constants
package mpc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DELTA,
    DIV,
    INC,
    COST,
    DECIDE
  } mpc_state_e;

  localparam int PROD_MULT = 2;

  localparam int DEF_WIDTH    = 32;
  localparam int DEF_FRAC     = 16;
  localparam int DEF_Z_STEP   = 656;          // 0.01 in Q16
  localparam int DEF_K1       = 655;
  localparam int DEF_K0       = 164;
  localparam int DEF_IREF_MIN = 0;
  localparam int DEF_IREF_MAX = 32'h000A0000; // 10.0 in Q16

endpackage

// File: rtl/mpc_seq_div.sv
// Restoring radix-2 unsigned divider, one quotient bit per clock.
//   i_clk, i_reset_n : clock, synchronous active-low reset (aborts a division)
//   i_start          : load i_num / i_den and begin NUM_W iterations
//   i_num, i_den     : unsigned dividend and divisor
//   o_done           : high during the final iteration cycle; o_quo holds the
//                      finished quotient from the following cycle onwards
//   o_quo            : unsigned quotient (floor)
module mpc_seq_div #(
  parameter int NUM_W = 48,
  parameter int DEN_W = 32
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_start,
  input  logic [NUM_W-1:0] i_num,
  input  logic [DEN_W-1:0] i_den,
  output logic             o_done,
  output logic [NUM_W-1:0] o_quo
);

  localparam int CNT_W = $clog2(NUM_W + 1);

  logic             running;
  logic [CNT_W-1:0] cnt;
  logic [DEN_W-1:0] rem;
  logic [DEN_W-1:0] den;
  logic [NUM_W-1:0] quo;
  logic [DEN_W:0]   rem_sh;
  logic             take;

  // The dividend is shifted out of quo MSB-first while quotient bits enter at
  // the LSB, so after NUM_W steps quo holds the quotient.
  always_comb begin
    rem_sh = {rem, quo[NUM_W-1]};
    take   = (rem_sh >= {1'b0, den});
  end

  assign o_done = running && (cnt == CNT_W'(1));
  assign o_quo  = quo;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      running <= 1'b0;
      cnt     <= '0;
    end else if (i_start) begin
      running <= 1'b1;
      cnt     <= CNT_W'(NUM_W);
    end else if (running) begin
      cnt <= cnt - CNT_W'(1);
      if (cnt == CNT_W'(1)) running <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_start) begin
      rem <= '0;
      den <= i_den;
      quo <= i_num;
    end else if (running) begin
      rem <= take ? DEN_W'(rem_sh - {1'b0, den}) : rem_sh[DEN_W-1:0];
      quo <= {quo[NUM_W-2:0], take};
    end
  end

endmodule

// File: rtl/mpc_inc_cond_param.sv
// MPC incremental-conductance MPPT controller (fixed point Q(WIDTH-FRAC).FRAC).
// Each accepted sample updates the current reference by +/-Z_STEP from the
// incremental-conductance rule, then picks the switch state whose predicted
// current is closer to that reference.
//   i_clk, i_reset_n       : clock, synchronous active-low reset
//   i_calc_DV              : sample strobe, honoured only while idle
//   i_Vpv, i_Ipv, i_Vout   : PV voltage, PV current, output voltage (signed)
//   o_switch               : switch command (1 = on)
//   o_iref                 : current reference (signed)
//   o_valid                : one-cycle strobe when o_switch/o_iref update
//   o_busy                 : a calculation is in progress
// Build option: define MPC_INC_COND_IREF_CLAMP_EN to clamp the new reference to
// [IREF_MIN, IREF_MAX]; otherwise only WIDTH saturation applies.
module mpc_inc_cond_param
  import mpc_pkg::*;
#(
  parameter int WIDTH    = DEF_WIDTH,
  parameter int FRAC     = DEF_FRAC,
  parameter int Z_STEP   = DEF_Z_STEP,
  parameter int K1       = DEF_K1,
  parameter int K0       = DEF_K0,
  parameter int IREF_MIN = DEF_IREF_MIN,
  parameter int IREF_MAX = DEF_IREF_MAX
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_calc_DV,
  input  logic signed [WIDTH-1:0] i_Vpv,
  input  logic signed [WIDTH-1:0] i_Ipv,
  input  logic signed [WIDTH-1:0] i_Vout,
  output logic                    o_switch,
  output logic signed [WIDTH-1:0] o_iref,
  output logic                    o_valid,
  output logic                    o_busy
);

  localparam int PW = PROD_MULT * WIDTH;
  localparam int QW = WIDTH + FRAC;

  localparam logic signed [WIDTH-1:0] S_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] S_MIN = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic signed [PW-1:0]    P_MAX = {{(PW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [PW-1:0]    P_MIN = {{(PW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam logic [QW-1:0]           Q_LIM = QW'(1) << (WIDTH-1);

  localparam logic signed [WIDTH-1:0] Z_W        = WIDTH'(Z_STEP);
  localparam logic signed [WIDTH-1:0] K1_W       = WIDTH'(K1);
  localparam logic signed [WIDTH-1:0] K0_W       = WIDTH'(K0);
  localparam logic signed [WIDTH-1:0] IREF_MIN_W = WIDTH'(IREF_MIN);
  localparam logic signed [WIDTH-1:0] IREF_MAX_W = WIDTH'(IREF_MAX);

  function automatic logic signed [WIDTH-1:0] sat_w(input logic signed [PW-1:0] x);
    if (x > P_MAX)      return S_MAX;
    else if (x < P_MIN) return S_MIN;
    else                return x[WIDTH-1:0];
  endfunction

  function automatic logic signed [WIDTH-1:0] add_sat(input logic signed [WIDTH-1:0] a,
                                                      input logic signed [WIDTH-1:0] b);
    logic signed [PW-1:0] ax, bx;
    ax = a;
    bx = b;
    return sat_w(ax + bx);
  endfunction

  function automatic logic signed [WIDTH-1:0] sub_sat(input logic signed [WIDTH-1:0] a,
                                                      input logic signed [WIDTH-1:0] b);
    logic signed [PW-1:0] ax, bx;
    ax = a;
    bx = b;
    return sat_w(ax - bx);
  endfunction

  // (a*b)>>>FRAC with the full-width product, then saturated
  function automatic logic signed [WIDTH-1:0] mulsh_sat(input logic signed [WIDTH-1:0] a,
                                                        input logic signed [WIDTH-1:0] b);
    logic signed [PW-1:0] ax, bx;
    ax = a;
    bx = b;
    return sat_w((ax * bx) >>> FRAC);
  endfunction

  function automatic logic signed [WIDTH-1:0] abs_sat(input logic signed [WIDTH-1:0] a);
    if (a == S_MIN)         return S_MAX;
    else if (a[WIDTH-1])    return -a;
    else                    return a;
  endfunction

  // Magnitude as unsigned; the most negative value maps to 2^(WIDTH-1) exactly.
  function automatic logic [WIDTH-1:0] abs_u(input logic signed [WIDTH-1:0] a);
    return a[WIDTH-1] ? $unsigned(-a) : $unsigned(a);
  endfunction

  function automatic logic signed [WIDTH-1:0] q_sat(input logic [QW-1:0] mag, input logic neg);
    if (neg) return (mag >= Q_LIM) ? S_MIN : -$signed(mag[WIDTH-1:0]);
    else     return (mag >= Q_LIM) ? S_MAX :  $signed(mag[WIDTH-1:0]);
  endfunction

`ifdef MPC_INC_COND_IREF_CLAMP_EN
  function automatic logic signed [WIDTH-1:0] clamp_iref(input logic signed [WIDTH-1:0] x);
    if (x < IREF_MIN_W)      return IREF_MIN_W;
    else if (x > IREF_MAX_W) return IREF_MAX_W;
    else                     return x;
  endfunction
`endif

  mpc_state_e state;
  logic       cost_ph;

  logic signed [WIDTH-1:0] vpv_prev, ipv_prev, iref_prev2, iref_cur;

  logic signed [WIDTH-1:0] vpv_p0, ipv_p0, vout_p0;
  logic signed [WIDTH-1:0] dv_p1, di_p1, dd_p1;
  logic                    qneg_p1;
  logic signed [WIDTH-1:0] iref_p2;
  logic signed [WIDTH-1:0] ipred1_p3, ipred0_p3;
  logic signed [WIDTH-1:0] g1_p4, g0_p4;

  logic signed [WIDTH-1:0] dv_c, di_c, q_c, sel_c, iref_step_c, iref_c;
  logic                    div_start, div_done;
  logic [QW-1:0]           div_num, div_quo;
  logic [WIDTH-1:0]        div_den;

  // dD tracks the reference trend over the last two decisions; it is kept
  // with the history but the cost function does not consume it.
  logic unused_dd;
  assign unused_dd = ^dd_p1;

  always_comb begin
    dv_c      = sub_sat(vpv_p0, vpv_prev);
    di_c      = sub_sat(ipv_p0, ipv_prev);
    div_start = (state == DELTA) && (dv_c != '0);
    div_num   = {abs_u(di_c), {FRAC{1'b0}}};
    div_den   = abs_u(dv_c);
    q_c       = q_sat(div_quo, qneg_p1);

    // With no voltage change the current change alone decides the direction.
    if (dv_p1 == '0) sel_c = di_p1;
    else             sel_c = add_sat(ipv_p0, mulsh_sat(q_c, vpv_p0));

    if (sel_c == '0)         iref_step_c = iref_cur;
    else if (sel_c[WIDTH-1]) iref_step_c = add_sat(iref_cur, Z_W);
    else                     iref_step_c = sub_sat(iref_cur, Z_W);

`ifdef MPC_INC_COND_IREF_CLAMP_EN
    iref_c = clamp_iref(iref_step_c);
`else
    iref_c = iref_step_c;
`endif
  end

`ifndef MPC_INC_COND_IREF_CLAMP_EN
  // Clamp limits only take effect in the clamping build.
  logic [WIDTH-1:0] unused_clamp_lim;
  assign unused_clamp_lim = IREF_MIN_W ^ IREF_MAX_W;
`endif

  mpc_seq_div #(
    .NUM_W(QW),
    .DEN_W(WIDTH)
  ) u_div (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_start  (div_start),
    .i_num    (div_num),
    .i_den    (div_den),
    .o_done   (div_done),
    .o_quo    (div_quo)
  );

  // Control FSM, outputs and sample history
  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state      <= IDLE;
      cost_ph    <= 1'b0;
      o_busy     <= 1'b0;
      o_valid    <= 1'b0;
      o_switch   <= 1'b0;
      o_iref     <= '0;
      vpv_prev   <= '0;
      ipv_prev   <= '0;
      iref_prev2 <= '0;
      iref_cur   <= '0;
    end else begin
      o_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (i_calc_DV) begin
            o_busy <= 1'b1;
            state  <= DELTA;
          end
        end
        DELTA:  state <= (dv_c == '0) ? INC : DIV;
        DIV:    if (div_done) state <= INC;
        INC: begin
          cost_ph <= 1'b0;
          state   <= COST;
        end
        // Two cycles: predictions first, then their distances to the reference.
        COST: begin
          cost_ph <= ~cost_ph;
          if (cost_ph) state <= DECIDE;
        end
        DECIDE: begin
          o_switch   <= (g1_p4 < g0_p4);
          o_iref     <= iref_p2;
          vpv_prev   <= vpv_p0;
          ipv_prev   <= ipv_p0;
          iref_prev2 <= iref_cur;
          iref_cur   <= iref_p2;
          o_valid    <= 1'b1;
          o_busy     <= 1'b0;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    case (state)
      // p0: sample capture
      IDLE: begin
        if (i_calc_DV) begin
          vpv_p0  <= i_Vpv;
          ipv_p0  <= i_Ipv;
          vout_p0 <= i_Vout;
        end
      end
      // p1: differences against history
      DELTA: begin
        dv_p1   <= dv_c;
        di_p1   <= di_c;
        dd_p1   <= sub_sat(iref_cur, iref_prev2);
        qneg_p1 <= di_c[WIDTH-1] ^ dv_c[WIDTH-1];
      end
      // p2: new reference
      INC: iref_p2 <= iref_c;
      // p3 / p4: predictions, then cost terms
      COST: begin
        if (!cost_ph) begin
          ipred1_p3 <= add_sat(ipv_p0, mulsh_sat(K1_W, vpv_p0));
          ipred0_p3 <= add_sat(ipv_p0, mulsh_sat(K0_W, sub_sat(vpv_p0, vout_p0)));
        end else begin
          g1_p4 <= abs_sat(sub_sat(iref_p2, ipred1_p3));
          g0_p4 <= abs_sat(sub_sat(iref_p2, ipred0_p3));
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mpc_inc_cond_param.sv
module tb_mpc_inc_cond_param;

  localparam longint Q    = 65536;
  localparam longint MAXV = 64'sd2147483647;
  localparam longint MINV = -64'sd2147483648;
  localparam longint ZS   = 656;
  localparam longint K1   = 655;
  localparam longint K0   = 164;
  localparam longint IMIN = 0;
  localparam longint IMAX = 64'h000A0000;

  logic               clk;
  logic               reset_n;
  logic               calc;
  logic signed [31:0] vpv, ipv, vout;
  logic               o_switch, o_valid, o_busy;
  logic signed [31:0] o_iref;

  int checks = 0;
  int errors = 0;

  // reference-model history
  longint m_vprev = 0, m_iprev = 0, m_iref = 0;

  mpc_inc_cond_param dut (
    .i_clk    (clk),
    .i_reset_n(reset_n),
    .i_calc_DV(calc),
    .i_Vpv    (vpv),
    .i_Ipv    (ipv),
    .i_Vout   (vout),
    .o_switch (o_switch),
    .o_iref   (o_iref),
    .o_valid  (o_valid),
    .o_busy   (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  function automatic longint sat(input longint x);
    if (x > MAXV) return MAXV;
    if (x < MINV) return MINV;
    return x;
  endfunction

  function automatic longint labs(input longint x);
    return (x < 0) ? -x : x;
  endfunction

  function automatic longint mulsh(input longint a, input longint b);
    return sat((a * b) >>> 16);
  endfunction

  function automatic longint abssat(input longint x);
    return sat(labs(x));
  endfunction

  // Computes the committed result of one sample straight from the control law.
  task automatic model(input longint v, input longint i, input longint vo,
                       output longint e_iref, output bit e_sw, output int e_lat);
    longint dv, di, mag, q, sel, iref, ip1, ip0, g1, g0;
    dv = sat(v - m_vprev);
    di = sat(i - m_iprev);
    if (dv == 0) begin
      sel   = di;
      e_lat = 5;
    end else begin
      mag   = (labs(di) << 16) / labs(dv);
      q     = ((di < 0) != (dv < 0)) ? sat(-mag) : sat(mag);
      sel   = sat(i + mulsh(q, v));
      e_lat = 53;
    end
    if (sel == 0)     iref = m_iref;
    else if (sel > 0) iref = sat(m_iref - ZS);
    else              iref = sat(m_iref + ZS);
`ifdef MPC_INC_COND_IREF_CLAMP_EN
    if (iref < IMIN) iref = IMIN;
    if (iref > IMAX) iref = IMAX;
`endif
    ip1  = sat(i + mulsh(K1, v));
    ip0  = sat(i + mulsh(K0, sat(v - vo)));
    g1   = abssat(sat(iref - ip1));
    g0   = abssat(sat(iref - ip0));
    e_sw = (g1 < g0);
    e_iref = iref;
    m_vprev = v;
    m_iprev = i;
    m_iref  = iref;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic run(input longint v, input longint i, input longint vo,
                     input bit glitch, input string tag);
    longint             e_iref;
    bit                 e_sw;
    int                 e_lat;
    int                 n;
    int                 extra;
    logic signed [31:0] prev_iref, exp_iref;
    prev_iref = 32'(m_iref);
    model(v, i, vo, e_iref, e_sw, e_lat);
    exp_iref = 32'(e_iref);
    @(negedge clk);
    vpv  = 32'(v);
    ipv  = 32'(i);
    vout = 32'(vo);
    calc = 1'b1;
    @(posedge clk); #1;
    calc = 1'b0;
    check({tag, " busy"}, 64'(o_busy), 64'(1));
    n = 0;
    while (!o_valid && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (n == 3) check({tag, " hold"}, o_iref, prev_iref);
      if (glitch && n == 10) begin
        calc = 1'b1;
        vpv  = 32'h0123_4567;
        ipv  = 32'h7654_3210;
      end
      if (glitch && n == 11) calc = 1'b0;
    end
    check({tag, " latency"}, 64'(n), 64'(e_lat));
    check({tag, " iref"}, o_iref, exp_iref);
    check({tag, " switch"}, 64'(o_switch), 64'(e_sw));
    check({tag, " idle"}, 64'(o_busy), 64'(0));
    @(posedge clk); #1;
    check({tag, " pulse"}, 64'(o_valid), 64'(0));
    if (glitch) begin
      extra = 0;
      repeat (60) begin
        @(posedge clk); #1;
        if (o_valid) extra++;
      end
      check({tag, " extra_valid"}, 64'(extra), 64'(0));
    end
  endtask

  task automatic reset_in_div();
    int extra;
    @(negedge clk);
    vpv  = 32'(m_vprev + 3 * Q);
    ipv  = 32'(m_iprev);
    vout = 32'(Q);
    calc = 1'b1;
    @(posedge clk); #1;
    calc = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset_n = 1'b0;
    @(posedge clk); #1;
    check("rst_div valid", 64'(o_valid), 64'(0));
    check("rst_div busy", 64'(o_busy), 64'(0));
    check("rst_div iref", o_iref, 32'sd0);
    check("rst_div switch", 64'(o_switch), 64'(0));
    reset_n = 1'b1;
    extra = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (o_valid) extra++;
    end
    check("rst_div no_valid", 64'(extra), 64'(0));
    m_vprev = 0;
    m_iprev = 0;
    m_iref  = 0;
  endtask

  initial begin
    longint             v, i, vo, lastv;
    logic signed [31:0] clamp_exp;
    reset_n = 1'b0;
    calc    = 1'b0;
    vpv     = '0;
    ipv     = '0;
    vout    = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset switch", 64'(o_switch), 64'(0));
    check("reset iref", o_iref, 32'sd0);
    check("reset valid", 64'(o_valid), 64'(0));
    check("reset busy", 64'(o_busy), 64'(0));
    reset_n = 1'b1;

    run(0, 0, 0, 1'b0, "zero");

    // decrement from the lower limit
    run(0, Q, 0, 1'b0, "clamp");
`ifdef MPC_INC_COND_IREF_CLAMP_EN
    clamp_exp = 32'sd0;
`else
    clamp_exp = -32'sd656;
`endif
    check("clamp const", o_iref, clamp_exp);

    run(10 * Q, 5 * Q, 8 * Q, 1'b0, "hist10");
    run(10 * Q, 6 * Q, 8 * Q, 1'b0, "dv0_dipos");
    run(10 * Q, 5 * Q, 8 * Q, 1'b0, "dv0_dineg");
    run(12 * Q, 4 * Q, 8 * Q, 1'b0, "qneg");

    run(2 * Q, 0, 0, 1'b0, "hist2");
    run(2 * Q + 1, MINV, 0, 1'b0, "qsat");

    run(5 * Q, Q, 2 * Q, 1'b1, "glitch");

    run(MAXV, 0, MINV, 1'b0, "ext_hi");
    run(MINV, MAXV, MAXV, 1'b0, "ext_lo");

    reset_in_div();

    lastv = 0;
    for (int k = 0; k < 16; k++) begin
      if ($urandom_range(0, 2) == 0) v = lastv;
      else v = longint'($urandom_range(0, 60 * 65536)) - 30 * Q;
      i  = longint'($urandom_range(0, 20 * 65536)) - 10 * Q;
      vo = longint'($urandom_range(0, 60 * 65536)) - 30 * Q;
      lastv = v;
      run(v, i, vo, 1'b0, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
